// File: rtl/am2909_next_address_controller.sv
// Am2910-class next-address control for a cascade of Am2909 slices: opcode decode, loop counter, stack-depth shadow.
// Optional SEQ_STACK_CHECK_EN: suppress stack over/underflow at the slices and flag it on a sticky ERR.
module am2909_next_address_controller #(
  parameter int unsigned CNT_W = 12,
  parameter int unsigned DEPTH = 4
) (
  input  logic             CP,
  input  logic             RST,
  input  logic [3:0]       I,
  input  logic             CC,
  input  logic             CCEN,
  input  logic [CNT_W-1:0] CNT_D,
  output logic [1:0]       S,
  output logic             FE,
  output logic             PUP,
  output logic             RE,
  output logic             ZERO,
  output logic             PL,
  output logic             MAP,
  output logic             VECT,
  output logic             FULL,
  output logic             CNT_Z,
  output logic             ERR
);

  localparam int unsigned SP_W = $clog2(DEPTH + 1);
  localparam logic [SP_W-1:0] SP_MAX = SP_W'(DEPTH);

  typedef enum logic [3:0] {
    OP_JZ, OP_CJS, OP_JMAP, OP_CJP, OP_PUSH, OP_JSRP, OP_CJV, OP_JRP,
    OP_RFCT, OP_RPCT, OP_CRTN, OP_CJPP, OP_LDCT, OP_LOOP, OP_CONT, OP_TWB
  } op_e;

  localparam logic [1:0] SRC_UPC = 2'b00;
  localparam logic [1:0] SRC_AR  = 2'b01;
  localparam logic [1:0] SRC_STK = 2'b10;
  localparam logic [1:0] SRC_D   = 2'b11;

  logic [CNT_W-1:0] r_cnt;
  logic [SP_W-1:0]  r_sp;
  logic             w_pass;
  logic             w_cnt_z;
  logic             w_push;
  logic             w_pop;
  logic             w_load;
  logic             w_dec;
  logic             w_clr;

  assign w_pass  = CCEN | ~CC;
  assign w_cnt_z = (r_cnt == '0);
  assign CNT_Z   = w_cnt_z;
  assign FULL    = (r_sp == SP_MAX);

`ifdef SEQ_STACK_CHECK_EN
  logic w_stk_err;
  logic r_err;
  assign w_stk_err = (w_push && (r_sp == SP_MAX)) || (w_pop && (r_sp == '0));
  assign ERR       = r_err;
`else
  assign ERR = 1'b0;
`endif

  // Opcode decode into Am2909 control lines and internal counter/stack actions.
  always_comb begin
    S      = SRC_UPC;
    RE     = 1'b1;
    ZERO   = 1'b1;
    PL     = 1'b0;
    MAP    = 1'b1;
    VECT   = 1'b1;
    w_push = 1'b0;
    w_pop  = 1'b0;
    w_load = 1'b0;
    w_dec  = 1'b0;
    w_clr  = 1'b0;
    case (op_e'(I))
      OP_JZ:   begin ZERO = 1'b0; w_clr = 1'b1; end
      OP_CJS:  if (w_pass) begin S = SRC_D; w_push = 1'b1; end
      OP_JMAP: begin S = SRC_D; PL = 1'b1; MAP = 1'b0; end
      OP_CJP:  if (w_pass) S = SRC_D;
      OP_PUSH: begin w_push = 1'b1; w_load = w_pass; end
      OP_JSRP: begin w_push = 1'b1; S = w_pass ? SRC_D : SRC_AR; end
      OP_CJV:  if (w_pass) begin S = SRC_D; PL = 1'b1; VECT = 1'b0; end
      OP_JRP:  S = w_pass ? SRC_D : SRC_AR;
      OP_RFCT: if (!w_cnt_z) begin S = SRC_STK; w_dec = 1'b1; end
               else w_pop = 1'b1;
      OP_RPCT: if (!w_cnt_z) begin S = SRC_D; w_dec = 1'b1; end
      OP_CRTN: if (w_pass) begin S = SRC_STK; w_pop = 1'b1; end
      OP_CJPP: if (w_pass) begin S = SRC_D; w_pop = 1'b1; end
      OP_LDCT: begin w_load = 1'b1; RE = 1'b0; end
      OP_LOOP: if (w_pass) w_pop = 1'b1;
               else S = SRC_STK;
      OP_CONT: ;
      OP_TWB:  if (w_pass) w_pop = 1'b1;
               else if (!w_cnt_z) begin S = SRC_STK; w_dec = 1'b1; end
               else begin S = SRC_D; w_pop = 1'b1; end
      default: ;
    endcase
    // Reset forces Y=0 with every D source and the stack/AR idle.
    if (RST) begin
      S      = SRC_UPC;
      RE     = 1'b1;
      ZERO   = 1'b0;
      PL     = 1'b1;
      MAP    = 1'b1;
      VECT   = 1'b1;
      w_push = 1'b0;
      w_pop  = 1'b0;
      w_load = 1'b0;
      w_dec  = 1'b0;
      w_clr  = 1'b0;
    end
    PUP = w_push;
`ifdef SEQ_STACK_CHECK_EN
    FE  = ~(w_push | w_pop) | w_stk_err;
`else
    FE  = ~(w_push | w_pop);
`endif
  end

  // Loop counter and saturating shadow of the slice stack pointer.
  always_ff @(posedge CP) begin
    if (RST) begin
      r_cnt <= '0;
      r_sp  <= '0;
    end else begin
      if (w_load)     r_cnt <= CNT_D;
      else if (w_dec) r_cnt <= r_cnt - CNT_W'(1);
      if (w_clr)                          r_sp <= '0;
      else if (w_push && r_sp != SP_MAX)  r_sp <= r_sp + SP_W'(1);
      else if (w_pop && r_sp != '0)       r_sp <= r_sp - SP_W'(1);
    end
  end

`ifdef SEQ_STACK_CHECK_EN
  always_ff @(posedge CP) begin
    if (RST)            r_err <= 1'b0;
    else if (w_stk_err) r_err <= 1'b1;
  end
`endif

endmodule

// File: doc/am2909_next_address_controller.md
Name: am2909_next_address_controller

Overview:
- Next-address controller for a cascade of Am2909 sequencer slices.
- Decodes a 4-bit microinstruction opcode and the test condition into the Am2909 control lines S, FE, PUP, ZERO and RE.
- Holds the loop counter and a shadow stack-depth counter, which drive FULL and the counter-dependent branches.
- Together with the Am2909 slices, forms an Am2910-class sequencer.

Parameters:
- CNT_W, 12, width of loop counter and CNT_D.
- DEPTH, 4, stack depth of the attached Am2909 slices.

Ports:
- CP  input  1  clock; all state updates on rising edge.
- RST  input  1  synchronous reset, active-high.
- I  input  4  opcode from pipeline register.
- CC  input  1  condition code, active-low (0 = true).
- CCEN  input  1  condition enable, active-low; 1 forces test pass.
- CNT_D  input  CNT_W  counter load value (same bus as Am2909 R).
- S  output  2  Am2909 source select: 00 uPC, 01 AR, 10 stack, 11 D.
- FE  output  1  stack enable to Am2909, active-low.
- PUP  output  1  1 = push, 0 = pop (valid when FE=0).
- RE  output  1  Am2909 AR load enable, active-low.
- ZERO  output  1  Am2909 ZERO, active-low; 0 forces Y=0.
- PL  output  1  pipeline D-source enable, active-low.
- MAP  output  1  mapping-PROM D-source enable, active-low.
- VECT  output  1  vector D-source enable, active-low.
- FULL  output  1  1 when SP==DEPTH.
- CNT_Z  output  1  1 when CNT==0.
- ERR  output  1  sticky stack error (see Optional Feature).

Behaviour:
- State: CNT[CNT_W-1:0], SP[2:0] (range 0..DEPTH). Reset value of both is 0.
- All outputs are combinational from I, CC, CCEN, CNT and SP.
- pass = CCEN | ~CC.
- Defaults: S=00, FE=1, PUP=0, RE=1, ZERO=1, PL=0, MAP=1, VECT=1.
- Push = FE=0, PUP=1, SP+1. Pop = FE=0, PUP=0, SP-1. dec = CNT-1.
- Opcodes:
  - 0 JZ: ZERO=0; SP<=0.
  - 1 CJS: pass: S=11, push. Fail: S=00.
  - 2 JMAP: S=11, PL=1, MAP=0.
  - 3 CJP: pass: S=11. Fail: S=00.
  - 4 PUSH: push, S=00. Pass: CNT<=CNT_D.
  - 5 JSRP: push. Pass: S=11. Fail: S=01.
  - 6 CJV: pass: S=11, PL=1, VECT=0. Fail: S=00.
  - 7 JRP: pass: S=11. Fail: S=01.
  - 8 RFCT: CNT!=0: S=10, dec. CNT==0: S=00, pop.
  - 9 RPCT: CNT!=0: S=11, dec. CNT==0: S=00.
  - 10 CRTN: pass: S=10, pop. Fail: S=00.
  - 11 CJPP: pass: S=11, pop. Fail: S=00.
  - 12 LDCT: CNT<=CNT_D, RE=0, S=00.
  - 13 LOOP: pass: S=00, pop. Fail: S=10.
  - 14 CONT: S=00.
  - 15 TWB: pass: S=00, pop. Fail with CNT!=0: S=10, dec. Fail with CNT==0: S=11, pop.
- Simultaneous events: load has priority over dec (no opcode issues both).
- Decrement never occurs at CNT==0, so CNT does not wrap.
- Boundary: push at SP==DEPTH leaves SP at DEPTH; pop at SP==0 leaves SP at 0. In both cases FE is still driven as decoded (macro absent).
- RST=1: ZERO=0, FE=1, RE=1, PL=MAP=VECT=1, S=00. Next edge sets CNT=0, SP=0 and ERR=0, aborting any loop in progress. Reset overrides I.

Optional Feature:
- Macro SEQ_STACK_CHECK_EN.
- Defined:
  - Push at SP==DEPTH or pop at SP==0 forces FE=1, suppressing the Am2909 stack operation.
  - On that edge ERR<=1; ERR is sticky until RST.
- Undefined: ERR tied 0; FE driven as decoded regardless of SP.

Test Plan:
- Reset: RST=1 for one CP edge, I=14 -> ZERO=0 during reset; after release CNT_Z=1, FULL=0, S=00, FE=1.
- CJS: CCEN=0, CC=0, I=1 -> S=11, FE=0, PUP=1, SP 0->1. Then CC=1 -> S=00, FE=1, SP unchanged.
- Loop: LDCT with CNT_D=3 (RE=0), then I=9 for four edges -> S=11 on the first three edges (CNT 3->2->1->0), S=00 on the fourth, CNT_Z=1.
- Stack: DEPTH pushes -> FULL=1. Fifth push -> SP stays 4. With SEQ_STACK_CHECK_EN: FE=1 and ERR=1 after the edge.
- JMAP/CJV: I=2 -> PL=1, MAP=0, S=11. I=6 with pass -> VECT=0; with fail -> VECT=1, S=00.
- TWB: CNT=0, fail, SP=1 -> S=11, pop, SP=0. CNT=2, fail -> S=10, CNT=1.
